// File: rtl/seq_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Counter must represent 0..width so a WIDTH=1 build still gets one bit.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: x - y - bin -> difference d, borrow bout.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/seq_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB-first over WIDTH
// cycles, with valid/ready handshakes on both the operand and result sides.
module seq_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             shift;
  logic             bit_d;
  logic             bit_bout;

  full_subtractor u_fs (
    .x   (a_sh[0]),
    .y   (b_sh[0]),
    .bin (borrow),
    .d   (bit_d),
    .bout(bit_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      diff_sh <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      a_sh    <= a;
      b_sh    <= b;
      diff_sh <= '0;
      borrow  <= b_in;
      cnt     <= '0;
    end else if (shift) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      diff_sh <= (diff_sh >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
      borrow  <= bit_bout;
      cnt     <= cnt + CW'(1);
    end
  end

  assign diff  = diff_sh;
  assign b_out = borrow;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed and random checks of seq_subtractor at WIDTH=4.
module tb_seq_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       b_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] diff;
  logic       b_out;

  int vectors;
  int miscompares;

  seq_subtractor #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .b_out    (b_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Drives one operation from IDLE through result transfer; called #1 after a posedge.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                        input int stall, output logic [3:0] od, output logic obo,
                        output int lat, output bit ok);
    int guard;
    ok  = 1'b1;
    lat = 0;
    od  = '0;
    obo = 1'b0;
    a = ia; b = ib; b_in = ibin; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) begin
      ok = 1'b0; in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    od  = diff;
    obo = b_out;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (diff !== 4'h0) begin
      miscompares++; $display("[TB] FAIL reset_diff: got %h expected 0", diff);
    end
    vectors++;
    if (b_out !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_b_out: got %b expected 0", b_out);
    end
  endtask

  task automatic test_directed();
    logic [3:0] ta [5] = '{4'h9, 4'h3, 4'h0, 4'hF, 4'hF};
    logic [3:0] tb [5] = '{4'h3, 4'h9, 4'h0, 4'h0, 4'hF};
    logic       tbi[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] td [5] = '{4'h6, 4'hA, 4'hF, 4'hE, 4'hF};
    logic       tbo[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] d;
    logic       bo;
    int         lat;
    bit         ok;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], tbi[i], 0, d, bo, lat, ok);
      vectors++;
      if (!ok) begin
        miscompares++; $display("[TB] FAIL directed_timeout[%0d]: got timeout expected result", i);
        continue;
      end
      vectors++;
      if (d !== td[i]) begin
        miscompares++; $display("[TB] FAIL directed_diff[%0d]: got %h expected %h", i, d, td[i]);
      end
      vectors++;
      if (bo !== tbo[i]) begin
        miscompares++; $display("[TB] FAIL directed_b_out[%0d]: got %b expected %b", i, bo, tbo[i]);
      end
      vectors++;
      if (lat !== 4) begin
        miscompares++; $display("[TB] FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
      end
      vectors++;
      if (int'(ta[i]) + 16 * int'(bo) !== int'(d) + int'(tb[i]) + int'(tbi[i])) begin
        miscompares++;
        $display("[TB] FAIL directed_invariant[%0d]: got a+16*bo=%0d expected d+b+bin=%0d",
                 i, int'(ta[i]) + 16 * int'(bo), int'(d) + int'(tb[i]) + int'(tbi[i]));
      end
    end
  endtask

  task automatic test_back_pressure();
    int lat;
    a = 4'h5; b = 4'h2; b_in = 1'b0; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bp_start_ready: got %b expected 1", in_ready);
    end
    @(posedge clk); #1;
    a = 4'h1; b = 4'h0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_shift_ready: got %b expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (lat !== 4) begin
      miscompares++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (diff !== 4'h3 || b_out !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL bp_hold[%0d]: got diff=%h b_out=%b expected diff=3 b_out=0", i, diff, b_out);
      end
      vectors++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL bp_flags[%0d]: got in_ready=%b out_valid=%b expected 0/1", i, in_ready, out_valid);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("[TB] FAIL bp_next_accept: got in_ready=%b expected 0", in_ready);
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    vectors++;
    if (out_valid !== 1'b1 || diff !== 4'h1 || b_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bp_second_op: got valid=%b diff=%h b_out=%b expected 1/1/0", out_valid, diff, b_out);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int         seen;
    logic [3:0] d;
    logic       bo;
    int         lat;
    bit         ok;
    a = 4'h9; b = 4'h3; b_in = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got out_valid=%b in_ready=%b diff=%h expected 0/1/0", out_valid, in_ready, diff);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("[TB] FAIL mid_reset_ghost: got %0d out_valid cycles expected 0", seen);
    end
    run_op(4'h7, 4'h7, 1'b0, 0, d, bo, lat, ok);
    vectors++;
    if (!ok || d !== 4'h0 || bo !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_reset_next: got ok=%b diff=%h b_out=%b expected 1/0/0", ok, d, bo);
    end
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    int guard;
    a = 4'hC; b = 4'h4; b_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (in_ready) accepts.push_back(cyc);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    out_ready = 1'b0;
    vectors++;
    if (accepts.size() < 3) begin
      miscompares++; $display("[TB] FAIL b2b_count: got %0d accepts expected at least 3", accepts.size());
    end else begin
      vectors++;
      if (accepts[1] - accepts[0] !== 6 || accepts[2] - accepts[1] !== 6) begin
        miscompares++;
        $display("[TB] FAIL b2b_spacing: got %0d,%0d expected 6,6",
                 accepts[1] - accepts[0], accepts[2] - accepts[1]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] ra, rb, d;
    logic       rbin, bo;
    logic [4:0] expect5;
    int         lat, results;
    bit         ok;
    results = 0;
    for (int i = 0; i < 200; i++) begin
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      rbin = 1'($urandom);
      expect5 = {1'b0, ra} - {1'b0, rb} - 5'(rbin);
      run_op(ra, rb, rbin, int'($urandom_range(0, 3)), d, bo, lat, ok);
      if (!ok) begin
        vectors++; miscompares++;
        $display("[TB] FAIL rand_timeout[%0d]: got timeout expected result", i);
        continue;
      end
      results++;
      vectors++;
      if ({bo, d} !== expect5) begin
        miscompares++;
        $display("[TB] FAIL rand_result[%0d]: %h-%h-%b got %h expected %h", i, ra, rb, rbin, {bo, d}, expect5);
      end
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++; $display("[TB] FAIL rand_dup[%0d]: got out_valid=%b expected 0", i, out_valid);
      end
    end
    vectors++;
    if (results !== 200) begin
      miscompares++; $display("[TB] FAIL rand_count: got %0d expected 200", results);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    b_in        = 1'b0;
    #2;
    test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_back_pressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
